// File: rtl/hack_pkg.sv
// Purpose: shared types and constants for the Hack boot loader and ROM integration.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hack_pkg;

    localparam int WORD_W          = 16;
    localparam int HACK_ROM_ADDR_W = 15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_SUM_HI,
        ST_SUM_LO,
        ST_DONE,
        ST_ERROR
    } ld_state_t;

endpackage

// File: rtl/hack_rom_loader.sv
// Purpose: boot loader; turns a length-prefixed, checksummed byte stream into sequential ROM writes.
// Latency: rom_we one cycle after a word's low byte is accepted; peak 1 word per 3 cycles.
// Backpressure: byte_ready low outside byte-consuming states; byte_valid stalls hold all state.
//
// Ports:
//   clock, reset        system clock, async active-high reset
//   start               one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   byte_valid/_data    upstream byte stream, byte_ready accepts
//   rom_we/addr/wdata   instruction-memory write port
//   cpu_reset           holds the CPU until a verified image is present
//   done, error         status levels
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W    = HACK_ROM_ADDR_W,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // One extra bit so a full-size image (MAX_WORDS) fits in the counter.
    localparam int CNT_W = ADDR_W + 1;

    ld_state_t         state;
    logic [7:0]        hi_byte;
    logic [CNT_W-1:0]  remaining;
    logic [WORD_W-1:0] sum;
    logic              accept;
    logic [WORD_W-1:0] rx_word;

    // Outputs are pure decodes of the state register, so nothing depends
    // combinationally on byte_valid.
    always_comb begin
        byte_ready = 1'b0;
        case (state)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI,
            ST_DATA_LO, ST_SUM_HI, ST_SUM_LO: byte_ready = 1'b1;
            default:                          byte_ready = 1'b0;
        endcase
    end

    assign rom_we    = (state == ST_WRITE);
    assign cpu_reset = (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERROR);

    assign accept  = byte_valid && byte_ready;
    assign rx_word = {hi_byte, byte_data};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            hi_byte   <= 8'h00;
            remaining <= '0;
            sum       <= '0;
            rom_addr  <= '0;
            rom_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state     <= ST_LEN_HI;
                        rom_addr  <= '0;
                        remaining <= '0;
                        sum       <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        hi_byte <= byte_data;
                        state   <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        if (rx_word == '0) begin
                            state <= ST_SUM_HI;
                        end else if (int'(rx_word) > MAX_WORDS) begin
                            // Rejected before any write, so rom_addr can never wrap.
                            state <= ST_ERROR;
                        end else begin
                            remaining <= CNT_W'(rx_word);
                            state     <= ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (accept) begin
                        hi_byte <= byte_data;
                        state   <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (accept) begin
                        rom_wdata <= rx_word;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    sum       <= sum + rom_wdata;
                    rom_addr  <= rom_addr + ADDR_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    state     <= (remaining == CNT_W'(1)) ? ST_SUM_HI : ST_DATA_HI;
                end
                ST_SUM_HI: begin
                    if (accept) begin
                        hi_byte <= byte_data;
                        state   <= ST_SUM_LO;
                    end
                end
                ST_SUM_LO: begin
                    if (accept) begin
                        state <= (rx_word == sum) ? ST_DONE : ST_ERROR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
module tb_hack_rom_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    // Small instance used only for the length-overflow boundary.
    logic        start4;
    logic        valid4;
    logic [7:0]  data4;
    logic        ready4;
    logic        we4;
    logic [3:0]  addr4;
    logic [15:0] wdata4;
    logic        cpu_reset4;
    logic        done4;
    logic        error4;

    int checks   = 0;
    int failures = 0;
    int ready_in_write = 0;
    int we4_cnt = 0;
    logic [14:0] wr_addr[$];
    logic [15:0] wr_data[$];

    hack_rom_loader dut (
        .clock(clock), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    hack_rom_loader #(.ADDR_W(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4),
        .byte_valid(valid4), .byte_data(data4), .byte_ready(ready4),
        .rom_we(we4), .rom_addr(addr4), .rom_wdata(wdata4),
        .cpu_reset(cpu_reset4), .done(done4), .error(error4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rom_we) begin
            wr_addr.push_back(rom_addr);
            wr_data.push_back(rom_wdata);
            if (byte_ready) ready_in_write++;
        end
        if (we4) we4_cnt++;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  waited = 0;
        bit  ok = 1'b0;
        repeat (gap) begin @(posedge clock); #1; end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!ok && waited < 40) begin
            @(negedge clock);
            if (byte_ready) ok = 1'b1;
            @(posedge clock); #1;
            waited++;
        end
        byte_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%h byte_ready never high in 40 cycles", b);
        end
    endtask

    // Image: 2 words 0x1234, 0xABCD, checksum 0xBE01.
    task automatic run_basic_image(input int maxgap, input bit inject_start, input string tag);
        logic [7:0] s [8];
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
        wr_addr.delete();
        wr_data.delete();
        ready_in_write = 0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (i == 3) begin
                checks++;
                if (rom_we !== 1'b1 || rom_addr !== 15'd0 || rom_wdata !== 16'h1234) begin
                    failures++;
                    $display("FAIL %s first_write_timing we=%b addr=%h data=%h want 1/0000/1234",
                             tag, rom_we, rom_addr, rom_wdata);
                end
            end
            if (i == 4 && inject_start) pulse_start();
            if (i == 6) begin
                checks++;
                if (cpu_reset !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s held_before_sum cpu_reset=%b done=%b want 1/0", tag, cpu_reset, done);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL %s done_state done=%b cpu_reset=%b error=%b want 1/0/0", tag, done, cpu_reset, error);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL %s write_count got=%0d want=2", tag, wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 15'd0 || wr_data[0] !== 16'h1234 ||
                wr_addr[1] !== 15'd1 || wr_data[1] !== 16'hABCD) begin
                failures++;
                $display("FAIL %s write_content got %h:%h %h:%h want 0000:1234 0001:abcd",
                         tag, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (ready_in_write != 0) begin
            failures++;
            $display("FAIL %s ready_in_write got=%0d want=0", tag, ready_in_write);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (byte_ready !== 1'b0 || rom_we !== 1'b0 || rom_addr !== 15'd0 || rom_wdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_datapath ready=%b we=%b addr=%h data=%h want 0/0/0/0",
                     byte_ready, rom_we, rom_addr, rom_wdata);
        end
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_status cpu_reset=%b done=%b error=%b want 1/0/0", cpu_reset, done, error);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (byte_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL idle_no_start ready=%b cpu_reset=%b want 0/1", byte_ready, cpu_reset);
        end
    endtask

    task automatic test_zero_len();
        logic [7:0] s [4];
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        checks++;
        if (done !== 1'b0 || byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_start_clears done=%b ready=%b want 0/1", done, byte_ready);
        end
        s = '{8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) send_byte(s[i], 0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || wr_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_len_ok done=%b error=%b writes=%0d want 1/0/0", done, error, wr_addr.size());
        end
        pulse_start();
        s = '{8'h00, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 4; i++) send_byte(s[i], 0);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || wr_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_len_badsum error=%b done=%b cpu_reset=%b writes=%0d want 1/0/1/0",
                     error, done, cpu_reset, wr_addr.size());
        end
    endtask

    task automatic test_overflow();
        // 17 words into a 16-word ROM: rejected right after LEN_LO.
        start4 = 1'b1; @(posedge clock); #1; start4 = 1'b0;
        valid4 = 1'b1; data4 = 8'h00; @(posedge clock); #1;
        data4 = 8'h11; @(posedge clock); #1;
        valid4 = 1'b0;
        checks++;
        if (error4 !== 1'b1 || ready4 !== 1'b0 || cpu_reset4 !== 1'b1) begin
            failures++;
            $display("FAIL overflow_17 error=%b ready=%b cpu_reset=%b want 1/0/1", error4, ready4, cpu_reset4);
        end
        repeat (3) @(posedge clock); #1;
        checks++;
        if (we4_cnt != 0) begin
            failures++;
            $display("FAIL overflow_no_write we_pulses=%0d want 0", we4_cnt);
        end
        // Exactly 16 words is legal and moves on to data.
        start4 = 1'b1; @(posedge clock); #1; start4 = 1'b0;
        valid4 = 1'b1; data4 = 8'h00; @(posedge clock); #1;
        data4 = 8'h10; @(posedge clock); #1;
        valid4 = 1'b0;
        checks++;
        if (error4 !== 1'b0 || ready4 !== 1'b1) begin
            failures++;
            $display("FAIL overflow_16_ok error=%b ready=%b want 0/1", error4, ready4);
        end
    endtask

    task automatic test_reset_midload();
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(posedge clock); #1;
        checks++;
        if (rom_addr !== 15'd1 || wr_addr.size() != 1) begin
            failures++;
            $display("FAIL midload_progress addr=%h writes=%0d want 0001/1", rom_addr, wr_addr.size());
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rom_we !== 1'b0 || cpu_reset !== 1'b1 || rom_addr !== 15'd0 || byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL midload_async we=%b cpu_reset=%b addr=%h ready=%b want 0/1/0/0",
                     rom_we, cpu_reset, rom_addr, byte_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        run_basic_image(0, 1'b0, "reload");
    endtask

    task automatic test_bad_sum();
        logic [7:0] s [6];
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL badsum_start done=%b cpu_reset=%b want 0/1", done, cpu_reset);
        end
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) send_byte(s[i], 0);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL badsum_status error=%b done=%b cpu_reset=%b want 1/0/1", error, done, cpu_reset);
        end
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 15'd0 || wr_data[0] !== 16'h1234) begin
            failures++;
            $display("FAIL badsum_write writes=%0d want 1 write of 1234 at 0", wr_addr.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        start4     = 1'b0;
        valid4     = 1'b0;
        data4      = 8'h00;

        test_reset();
        run_basic_image(0, 1'b0, "basic");
        test_zero_len();
        test_overflow();
        run_basic_image(3, 1'b1, "gaps");
        test_reset_midload();
        test_bad_sum();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
